// File: rtl/keypad_if.sv
// Keypad matrix bundle: column drive and row sense toward the keypad, key report toward the debouncer.
// The scanner takes the master side, the keypad/consumer takes the slave side.
interface keypad_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_pressed;

  modport master (
    input  rows,
    output cols,
    output key_code,
    output key_pressed
  );

  modport slave (
    output rows,
    input  cols,
    input  key_code,
    input  key_pressed
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, locks the first key found and
// holds it until that key's row releases. No debouncing is done here.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 4800
) (
  input logic      clk,
  input logic      reset,
  keypad_if.master kp
);

  // state | meaning
  // SCAN  | drive col_idx, count settle cycles, sample rows_s at terminal count
  // HOLD  | key locked at (lock_row, col_idx); watch only that row for release
  typedef enum logic {SCAN, HOLD} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  rows_m, rows_s;
  logic [1:0]  col_idx, col_nx;
  logic [1:0]  lock_row, lock_nx;
  logic [15:0] settle_cnt, cnt_nx;
  logic [3:0]  code_nx;
  logic        pressed_nx;
  logic        hit;
  logic [1:0]  hit_row;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clk; only the second flop is ever used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_m <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      rows_m <= kp.rows;
      rows_s <= rows_m;
    end
  end

  // Descending scan so the lowest-index active row is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s[i]) begin
        hit     = 1'b1;
        hit_row = 2'(i);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    col_nx     = col_idx;
    cnt_nx     = settle_cnt;
    lock_nx    = lock_row;
    code_nx    = kp.key_code;
    pressed_nx = kp.key_pressed;
    case (state)
      SCAN: begin
        if (settle_cnt == SETTLE_LAST) begin
          cnt_nx = 16'd0;
          if (hit) begin
            lock_nx    = hit_row;
            code_nx    = key_map(hit_row, col_idx);
            pressed_nx = 1'b1;
            state_nx   = HOLD;
          end else begin
            col_nx = col_idx + 2'd1;
          end
        end else begin
          cnt_nx = settle_cnt + 16'd1;
        end
      end
      HOLD: begin
        if (rows_s[lock_row]) begin
          pressed_nx = 1'b0;
          col_nx     = col_idx + 2'd1;
          cnt_nx     = 16'd0;
          state_nx   = SCAN;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  // cols is built from the next column index so it tracks col_idx with no lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= SCAN;
      col_idx        <= 2'd0;
      settle_cnt     <= 16'd0;
      lock_row       <= 2'd0;
      kp.cols        <= 4'b1110;
      kp.key_code    <= 4'h0;
      kp.key_pressed <= 1'b0;
    end else begin
      state          <= state_nx;
      col_idx        <= col_nx;
      settle_cnt     <= cnt_nx;
      lock_row       <= lock_nx;
      kp.cols        <= ~(4'b0001 << col_nx);
      kp.key_code    <= code_nx;
      kp.key_pressed <= pressed_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives rows from cols, a
// behavioural scan model predicts outputs every cycle, directed steps pin literals.
module tb_keypad_scanner;
  localparam int S = 4;
  localparam string KEYS = "123A456B789CE0FD";

  logic clk;
  logic reset;
  logic [3:0][3:0] press;  // press[row][col]

  int n_checks;
  int n_fail;

  keypad_if kp ();

  keypad_scanner #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp.master)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; rows are pulled up otherwise.
  always_comb begin
    kp.rows = 4'hF;
    for (int r = 0; r < 4; r++)
      kp.rows[r] = ~|(press[r] & ~kp.cols);
  end

  function automatic logic [3:0] hexval(input byte ch);
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  function automatic int first_zero(input logic [3:0] v);
    for (int r = 0; r < 4; r++)
      if (!v[r]) return r;
    return 0;
  endfunction

  // Behavioural model: dwell S cycles per column looking at rows two edges old.
  int         m_col, m_dwell, m_row;
  logic       m_hold, m_pressed;
  logic [3:0] m_code, h0, h1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_col <= 0; m_dwell <= 0; m_row <= 0; m_hold <= 1'b0;
      m_pressed <= 1'b0; m_code <= 4'h0; h0 <= 4'hF; h1 <= 4'hF;
    end else begin
      if (m_hold) begin
        if (h1[m_row]) begin
          m_hold <= 1'b0; m_pressed <= 1'b0; m_col <= (m_col + 1) % 4; m_dwell <= 0;
        end
      end else if (m_dwell == S - 1) begin
        m_dwell <= 0;
        if (h1 != 4'hF) begin
          m_row     <= first_zero(h1);
          m_code    <= hexval(KEYS[first_zero(h1) * 4 + m_col]);
          m_hold    <= 1'b1;
          m_pressed <= 1'b1;
        end else begin
          m_col <= (m_col + 1) % 4;
        end
      end else begin
        m_dwell <= m_dwell + 1;
      end
      h1 <= h0;
      h0 <= kp.rows;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [3:0] e_cols;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_cols = 4'hF ^ (4'h1 << m_col);
        chk("model_cols", {28'd0, kp.cols}, {28'd0, e_cols});
        chk("model_pressed", {31'd0, kp.key_pressed}, {31'd0, m_pressed});
        chk("model_code", {28'd0, kp.key_code}, {28'd0, m_code});
      end
    end
  endtask

  task automatic wait_pressed(input logic val, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kp.key_pressed === val) break;
    end
    chk(name, {31'd0, kp.key_pressed}, {31'd0, val});
  endtask

  task automatic press_key(input int r, input int c, input logic [3:0] exp, input string name);
    press[r][c] = 1'b1;
    wait_pressed(1'b1, 4 * S + 10, {name, "_lock"});
    chk({name, "_code"}, {28'd0, kp.key_code}, {28'd0, exp});
    press[r][c] = 1'b0;
    wait_pressed(1'b0, 10, {name, "_release"});
  endtask

  logic [3:0] step_cols [4];

  initial begin
    step_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    n_checks = 0;
    n_fail   = 0;
    clk   = 1'b0;
    reset = 1'b1;
    press = '0;
    fork
      compare_loop();
    join_none

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-cycle while scanning column 1
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_cols", {28'd0, kp.cols}, 32'hE);
    chk("rst_pressed", {31'd0, kp.key_pressed}, 32'd0);
    chk("rst_code", {28'd0, kp.key_code}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i % 4 == 0) chk("idle_step", {28'd0, kp.cols}, {28'd0, step_cols[i / 4 - 1]});
    end

    // Single key row 1 / col 2
    press[1][2] = 1'b1;
    wait_pressed(1'b1, 4 * S + 10, "single_lock");
    chk("single_code", {28'd0, kp.key_code}, 32'h6);
    chk("single_cols", {28'd0, kp.cols}, 32'hB);
    repeat (5) @(negedge clk);
    chk("single_hold_cols", {28'd0, kp.cols}, 32'hB);
    press[1][2] = 1'b0;
    repeat (2) @(negedge clk);
    chk("release_lat2", {31'd0, kp.key_pressed}, 32'd1);
    @(negedge clk);
    chk("release_lat3", {31'd0, kp.key_pressed}, 32'd0);
    chk("release_cols", {28'd0, kp.cols}, 32'h7);
    chk("release_code", {28'd0, kp.key_code}, 32'h6);

    // Corner keys
    press_key(3, 1, 4'h0, "corner_r3c1");
    press_key(3, 3, 4'hD, "corner_r3c3");
    press_key(0, 0, 4'h1, "corner_r0c0");

    // Two rows in column 3
    press[0][3] = 1'b1;
    press[2][3] = 1'b1;
    wait_pressed(1'b1, 4 * S + 10, "samecol_lock");
    chk("samecol_code", {28'd0, kp.key_code}, 32'hA);
    press[2][3] = 1'b0;
    repeat (6) @(negedge clk);
    chk("samecol_other_row", {31'd0, kp.key_pressed}, 32'd1);
    press[0][3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("samecol_release", {31'd0, kp.key_pressed}, 32'd0);
    chk("samecol_next_col", {28'd0, kp.cols}, 32'hE);

    // Two columns, scan currently at column 0
    press[0][1] = 1'b1;
    press[0][3] = 1'b1;
    wait_pressed(1'b1, 4 * S + 10, "diffcol_lock");
    chk("diffcol_code", {28'd0, kp.key_code}, 32'h2);
    chk("diffcol_cols", {28'd0, kp.cols}, 32'hD);
    press[0][1] = 1'b0;
    wait_pressed(1'b0, 10, "diffcol_release");
    chk("diffcol_resume", {28'd0, kp.cols}, 32'hB);
    wait_pressed(1'b1, 4 * S + 10, "diffcol_relock");
    chk("diffcol_code2", {28'd0, kp.key_code}, 32'hA);
    chk("diffcol_cols2", {28'd0, kp.cols}, 32'h7);

    // Reset while holding
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("hold_rst_pressed", {31'd0, kp.key_pressed}, 32'd0);
    chk("hold_rst_cols", {28'd0, kp.cols}, 32'hE);
    chk("hold_rst_code", {28'd0, kp.key_code}, 32'h0);
    press = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", {31'd0, kp.key_pressed}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives the columns of a 4x4 matrix keypad, samples the rows, and reports the first key it detects as a 4-bit hex code plus a level `key_pressed` flag. It sits upstream of the keypad debouncer, feeding its `sig_in` (the key code) and `key_pressed` inputs. It does no debouncing; contact bounce passes through and is filtered downstream.

## Interface
- `SETTLE_CYCLES`, default 4800: cycles each column is driven before rows are sampled (100 us at 48 MHz); legal range 3 to 65535.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `rows` in 4: keypad row inputs, active low (pulled up externally), asynchronous to `clk`; bit 0 = top row.
- `cols` out 4: column drive, active low, exactly one bit low at all times; bit 0 = left column.
- `key_code` out 4: hex code of the held key; valid while `key_pressed`=1.
- `key_pressed` out 1: high while a locked key remains pressed.

## Operation
- `rows` passes through a 2-flop synchronizer (`rows_s`). All decisions use `rows_s` only.
- Key map, `[row][col]`:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: E 0 F D
- Registers:
  - `col_idx` (2 bits).
  - `settle_cnt` (16 bits).
  - `lock_row` (2 bits).
  - State, one of SCAN or HOLD.
- `cols` = ~(4'b0001 << `col_idx`), registered.
- SCAN:
  - `settle_cnt` increments every cycle.
  - When `settle_cnt` == SETTLE_CYCLES-1, sample `rows_s`:
    - If any bit is 0: take the lowest-index 0 bit as the row. Load `lock_row`, load `key_code` from the map at [row][`col_idx`], set `key_pressed`=1, and go to HOLD. `col_idx` is unchanged.
    - If all bits are 1: `col_idx` <= `col_idx`+1 (wraps 3->0) and `settle_cnt` <= 0.
- HOLD:
  - `cols` stays on the locked column.
  - Only `rows_s[lock_row]` is monitored. Other rows in the same column and keys in other columns are ignored.
  - When `rows_s[lock_row]`==1: set `key_pressed`=0, `col_idx` <= `col_idx`+1, `settle_cnt` <= 0, and go to SCAN.
  - `key_code` holds its last value after release. It changes only on a new lock.
- Simultaneous presses:
  - Same column: the lowest row index wins.
  - Different columns: the column reached first in scan order wins.
- Reset (asynchronous, any time, including mid-settle or in HOLD) forces:
  - State = SCAN, `col_idx`=0, `settle_cnt`=0, `lock_row`=0.
  - `cols`=4'b1110, `key_code`=4'h0, `key_pressed`=0.
  - Synchronizer flops = 4'b1111.

## Timing
- Row-to-`rows_s` latency: 2 cycles.
- Each column is driven for exactly SETTLE_CYCLES cycles when no key is found. A full idle scan takes 4*SETTLE_CYCLES cycles.
- `key_pressed` and `key_code` update in the cycle after the sampling edge, i.e. SETTLE_CYCLES cycles after the column became active.
- Worst-case detection latency from a row going low: 4*SETTLE_CYCLES + 2 cycles.
- Release: `key_pressed` falls 3 cycles after the locked row goes high (2 sync + 1 register). On that same edge `cols` advances to the next column.
- `key_pressed` and `key_code` change on the same edge. There is no cycle in which `key_pressed`=1 with a stale code.

## Test plan
Use SETTLE_CYCLES=4 for all scenarios.
- **Reset:** assert `reset` asynchronously mid-cycle -> immediately `cols`=1110, `key_pressed`=0, `key_code`=0. After release with `rows`=1111, `cols` steps 1110->1101->1011->0111->1110, 4 cycles per step.
- **Single key:** hold the key at row 1 / col 2 (row pulled low only while `cols[2]`=0) -> `key_pressed`=1, `key_code`=6. `cols` stays 1011 while held. Release -> `key_pressed`=0 three cycles later, `cols`=0111, `key_code` stays 6.
- **Corner keys:** press row 3/col 1 -> `key_code`=0. Press row 3/col 3 -> `key_code`=D. Press row 0/col 0 -> `key_code`=1.
- **Simultaneous presses, same column:** rows 0 and 2 in col 3 -> `key_code`=A. Releasing row 2 only -> `key_pressed` stays 1. Releasing row 0 -> `key_pressed` drops.
- **Simultaneous presses, different columns:** col 1 row 0 and col 3 row 0, with the scan currently at col 0 -> `key_code`=2. Hold both, release col 1 -> scanning resumes and `key_code`=A with `key_pressed`=1 after col 2 has settled.
- **Reset in HOLD:** assert `reset` while `key_pressed`=1 -> `key_pressed`=0 and `cols`=1110 without waiting for `clk`.
